// File: rtl/fifo_burst_reader_pkg.sv
// fifo_rd_pkg: shared types and constants for fifo_burst_reader.
//   state_t        burst FSM states
//   SKID_DEPTH     number of skid-buffer entries
//   SKID_PW        skid-buffer pointer width
//   skid_ptr_next  circular pointer increment (wraps 2 -> 0)
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int unsigned SKID_DEPTH = 3;
    localparam int unsigned SKID_PW    = 2;

    typedef logic [SKID_PW-1:0] skid_ptr_t;

    function automatic skid_ptr_t skid_ptr_next(input skid_ptr_t p);
        return (p == skid_ptr_t'(SKID_DEPTH - 1)) ? '0 : p + skid_ptr_t'(1);
    endfunction

endpackage

// File: rtl/fifo_burst_reader_if.sv
// fifo_burst_reader_if: FIFO read-side and output-stream signals of the
// burst reader.
//   fifo_empty  FIFO empty flag              (FIFO -> reader)
//   fifo_rd_en  FIFO read request            (reader -> FIFO)
//   fifo_data   FIFO read data, one cycle after an accepted read
//   m_valid     stream data valid            (reader -> consumer)
//   m_ready     stream accept                (consumer -> reader)
//   m_data      stream data                  (reader -> consumer)
// Modports: master = reader side, slave = FIFO/consumer side.
interface fifo_burst_reader_if #(
    parameter int W = 32
);
    logic         fifo_empty;
    logic         fifo_rd_en;
    logic [W-1:0] fifo_data;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_data;

    modport master (
        input  fifo_empty, fifo_data, m_ready,
        output fifo_rd_en, m_valid, m_data
    );

    modport slave (
        output fifo_empty, fifo_data, m_ready,
        input  fifo_rd_en, m_valid, m_data
    );
endinterface

// File: rtl/fifo_burst_reader_rd_skid_buf.sv
// rd_skid_buf: 3-entry circular buffer holding words read from the FIFO
// until the downstream consumer accepts them.
//   clk, rst   clock, asynchronous active-high reset
//   push       write push_data at the tail
//   push_data  word to store
//   pop        remove the head entry (ignored when empty)
//   occ        number of stored entries (0..3)
//   head       entry at the read pointer
module rd_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [W-1:0]       push_data,
    input  logic               pop,
    output logic [SKID_PW-1:0] occ,
    output logic [W-1:0]       head
);

    logic [W-1:0] mem [SKID_DEPTH];
    skid_ptr_t    wr_ptr;
    skid_ptr_t    rd_ptr;
    logic         pop_ok;

    assign pop_ok = pop && (occ != '0);
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= skid_ptr_next(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= skid_ptr_next(rd_ptr);
            end
            // Simultaneous push and pop leave occupancy unchanged.
            case ({push, pop_ok})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: on a start command, reads exactly len words from a FIFO
// with a registered read port and forwards them on a valid/ready stream.
//   clk, rst  clock, asynchronous active-high reset
//   start     single-cycle burst request, sampled in IDLE only
//   len       burst length in words, sampled with start
//   busy      high while a burst is running or completing
//   done      one-cycle pulse at the end of a burst
//   bus       FIFO read port and output stream (master modport)
module fifo_burst_reader
    import fifo_rd_pkg::*;
#(
    parameter int W  = 32,
    parameter int LW = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [LW-1:0]              len,
    output logic                       busy,
    output logic                       done,
    fifo_burst_reader_if.master        bus
);

    state_t              state_q;
    state_t              state_d;
    logic [LW-1:0]       len_q;
    logic [LW-1:0]       issued;
    logic [LW-1:0]       delivered;
    logic                inflight;
    logic [SKID_PW-1:0]  occ;
    logic [SKID_PW:0]    pending;
    logic                rd_en;
    logic                xfer;
    logic                last;

    // Words already committed to the skid buffer: stored plus the one in the
    // FIFO read pipeline. Reads stop once that reaches the buffer depth, so
    // the buffer can never overflow under backpressure.
    assign pending = {1'b0, occ} + {{SKID_PW{1'b0}}, inflight};

    assign rd_en = (state_q == RUN) && !bus.fifo_empty && (issued < len_q)
                   && (pending < (SKID_PW + 1)'(SKID_DEPTH));
    assign xfer  = bus.m_valid && bus.m_ready;
    assign last  = xfer && (delivered + LW'(1) == len_q);

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = (occ != '0);

    rd_skid_buf #(
        .W (W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (bus.fifo_data),
        .pop       (xfer),
        .occ       (occ),
        .head      (bus.m_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q     <= '0;
            issued    <= '0;
            delivered <= '0;
            inflight  <= 1'b0;
        end else begin
            // The FIFO presents read data one edge after the read is accepted.
            inflight <= rd_en;
            if (state_q == IDLE && start && len != '0) begin
                len_q     <= len;
                issued    <= '0;
                delivered <= '0;
            end else begin
                if (rd_en) begin
                    issued <= issued + LW'(1);
                end
                if (xfer && state_q == RUN) begin
                    delivered <= delivered + LW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: scoreboard bench for fifo_burst_reader. A queue
// models the FIFO; every word destined for the stream is also pushed into
// the expected queue, and a negedge monitor checks each transfer, each read
// request and each done pulse against the rules of the burst reader.
module tb_fifo_burst_reader;

    localparam int W  = 32;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LW-1:0] len;
    logic          busy;
    logic          done;

    fifo_burst_reader_if #(.W(W)) ifc ();

    fifo_burst_reader #(.W(W), .LW(LW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .len   (len),
        .busy  (busy),
        .done  (done),
        .bus   (ifc.master)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          errors  = 0;
    int          cyc     = 0;
    logic [W-1:0] fq[$];      // FIFO contents
    logic [W-1:0] exp_q[$];   // words the stream must deliver, in order
    int          rd_cyc[$];
    int          xf_cyc[$];
    int          reads, xfers, cur_len;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          busy_cyc = 0;
    bit          rand_ready = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fifo_push(input logic [W-1:0] w, input bit to_stream);
        fq.push_back(w);
        ifc.fifo_empty = 1'b0;
        if (to_stream) exp_q.push_back(w);
    endtask

    task automatic clear_burst_stats(input int l);
        reads = 0;
        xfers = 0;
        cur_len = l;
        rd_cyc.delete();
        xf_cyc.delete();
    endtask

    // Pulses start for one cycle; returns the edge number that sampled it.
    task automatic pulse_start(input int l, output int n);
        clear_burst_stats(l);
        start = 1'b1;
        len   = LW'(l);
        tick();
        n     = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int bound);
        int k = 0;
        while (done_cnt == d0 && k < bound) begin
            tick();
            k++;
        end
        if (done_cnt == d0) begin
            vectors++;
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected one", bound);
        end
    endtask

    task automatic end_checks(input string tag, input int l, input int d0);
        tick();
        tick();
        check({tag, "_exp_empty"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_reads"}, 64'(reads), 64'(l));
        check({tag, "_xfers"}, 64'(xfers), 64'(l));
        check({tag, "_done_cnt"}, 64'(done_cnt), 64'(d0 + 1));
        check({tag, "_busy_low"}, 64'(busy), 64'd0);
    endtask

    // FIFO model: registered read port.
    initial begin
        bit take;
        ifc.fifo_data  = '0;
        ifc.fifo_empty = 1'b1;
        forever begin
            @(negedge clk);
            take = ifc.fifo_rd_en && (fq.size() != 0) && !rst;
            @(posedge clk);
            #1;
            if (take && fq.size() != 0) begin
                ifc.fifo_data  = fq.pop_front();
                ifc.fifo_empty = (fq.size() == 0);
            end
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) ifc.m_ready = ($urandom % 4) != 0;
    end

    // Monitor / scoreboard.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (ifc.fifo_rd_en) begin
                check("rd_while_empty", 64'(ifc.fifo_empty), 64'd0);
                check("rd_over_depth", 64'((reads - xfers) < 3), 64'd1);
                check("rd_over_len", 64'(reads < cur_len), 64'd1);
                reads++;
                rd_cyc.push_back(cyc);
            end
            if (ifc.m_valid && ifc.m_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL m_data_extra: got %0h, expected no word", ifc.m_data);
                end else begin
                    check("m_data", 64'(ifc.m_data), 64'(exp_q.pop_front()));
                end
                xfers++;
                xf_cyc.push_back(cyc);
            end
            if (done) begin
                check("done_after_last", 64'(xfers), 64'(cur_len));
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy) busy_cyc++;
        end
    end

    initial begin
        int n, d0, b0, k, l, pre, rem;
        logic [W-1:0] w;
        rst = 1'b1;
        start = 1'b0;
        len = '0;
        ifc.m_ready = 1'b0;
        clear_burst_stats(0);
        #2;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rd_en", 64'(ifc.fifo_rd_en), 64'd0);
        check("rst_m_valid", 64'(ifc.m_valid), 64'd0);
        check("rst_m_data", 64'(ifc.m_data), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Burst of 4 at full throughput.
        ifc.m_ready = 1'b1;
        for (int i = 0; i < 4; i++) fifo_push(32'hA0 + 32'(i), 1'b1);
        d0 = done_cnt;
        pulse_start(4, n);
        wait_done(d0, 50);
        for (int i = 0; i < 4; i++) begin
            check("t1_rd_cycle", 64'(rd_cyc.size() > i ? rd_cyc[i] : -1), 64'(n + i));
            check("t1_xf_cycle", 64'(xf_cyc.size() > i ? xf_cyc[i] : -1), 64'(n + 2 + i));
        end
        end_checks("t1", 4, d0);

        // Backpressure: 3 words buffered, then drained.
        ifc.m_ready = 1'b0;
        for (int i = 0; i < 6; i++) fifo_push(32'hB0 + 32'(i), 1'b1);
        d0 = done_cnt;
        pulse_start(6, n);
        for (int i = 0; i < 10; i++) tick();
        check("t2_reads_stalled", 64'(reads), 64'd3);
        check("t2_m_valid", 64'(ifc.m_valid), 64'd1);
        check("t2_fifo_left", 64'(fq.size()), 64'd3);
        ifc.m_ready = 1'b1;
        wait_done(d0, 50);
        end_checks("t2", 6, d0);

        // FIFO runs empty mid-burst.
        for (int i = 0; i < 2; i++) fifo_push(32'hC0 + 32'(i), 1'b1);
        d0 = done_cnt;
        pulse_start(5, n);
        for (int i = 0; i < 8; i++) tick();
        check("t3_reads_stalled", 64'(reads), 64'd2);
        k = cyc;
        for (int i = 2; i < 5; i++) fifo_push(32'hC0 + 32'(i), 1'b1);
        wait_done(d0, 50);
        check("t3_resume_cycle", 64'(rd_cyc.size() > 2 ? rd_cyc[2] : -1), 64'(k));
        end_checks("t3", 5, d0);

        // Zero-length burst.
        d0 = done_cnt;
        b0 = busy_cyc;
        pulse_start(0, n);
        for (int i = 0; i < 4; i++) tick();
        check("t4_reads", 64'(reads), 64'd0);
        check("t4_done_cnt", 64'(done_cnt), 64'(d0 + 1));
        check("t4_done_cycle", 64'(done_cyc), 64'(n));
        check("t4_busy_cycles", 64'(busy_cyc - b0), 64'd1);

        // start while busy is ignored.
        for (int i = 0; i < 5; i++) fifo_push(32'hD0 + 32'(i), 1'b1);
        for (int i = 0; i < 3; i++) fifo_push(32'hEE0 + 32'(i), 1'b0);
        d0 = done_cnt;
        pulse_start(5, n);
        tick();
        tick();
        start = 1'b1;
        len = LW'(9);
        tick();
        start = 1'b0;
        wait_done(d0, 50);
        end_checks("t5", 5, d0);
        for (int i = 0; i < 5; i++) tick();
        check("t5_extra_untouched", 64'(fq.size()), 64'd3);
        fq.delete();
        ifc.fifo_empty = 1'b1;

        // Reset mid-burst, then a fresh burst.
        for (int i = 0; i < 8; i++) fifo_push(32'hF0 + 32'(i), 1'b1);
        d0 = done_cnt;
        pulse_start(8, n);
        k = 0;
        while (xfers < 2 && k < 50) begin
            tick();
            k++;
        end
        check("t6_reached_two", 64'(xfers), 64'd2);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_done", 64'(done), 64'd0);
        check("t6_rst_rd_en", 64'(ifc.fifo_rd_en), 64'd0);
        check("t6_rst_m_valid", 64'(ifc.m_valid), 64'd0);
        check("t6_rst_m_data", 64'(ifc.m_data), 64'd0);
        fq.delete();
        exp_q.delete();
        ifc.fifo_empty = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("t6_no_done", 64'(done_cnt), 64'(d0));
        fifo_push(32'h1B0, 1'b1);
        fifo_push(32'h1B1, 1'b1);
        d0 = done_cnt;
        pulse_start(2, n);
        wait_done(d0, 50);
        end_checks("t6", 2, d0);

        // Randomized bursts: random length, FIFO fill timing, backpressure
        // and ignored start pulses.
        rand_ready = 1'b1;
        for (int b = 0; b < 25; b++) begin
            l   = int'($urandom_range(1, 20));
            pre = int'($urandom_range(0, l));
            rem = l - pre;
            for (int i = 0; i < pre; i++) fifo_push($urandom, 1'b1);
            d0 = done_cnt;
            pulse_start(l, n);
            k = 0;
            while ((done_cnt == d0 || rem > 0) && k < 2000) begin
                tick();
                k++;
                start = 1'b0;
                if (rem > 0 && ($urandom % 3) == 0) begin
                    fifo_push($urandom, 1'b1);
                    rem--;
                end
                if (busy && ($urandom % 8) == 0) begin
                    start = 1'b1;
                    len   = LW'($urandom_range(1, 30));
                end
            end
            start = 1'b0;
            if (done_cnt == d0) begin
                vectors++;
                errors++;
                $display("FAIL rand_timeout: burst %0d got no done, expected one", b);
            end
            end_checks("rand", l, d0);
        end
        rand_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
